regfile_write_queue: RTL

- Producer-side front end for the 32x32 register file: the block that generates its write port (wr, writeData, writeEN).
- Accepts write-back results from the ALU stage and the memory/load stage, buffers them in order in a small FIFO, and retires one write per cycle into the register file's single write port.
- Provides forwarding lookups so in-flight writes are visible to readers before they land.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wq_fwd_lookup.sv | 37 +++
 rtl/regfile_write_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the queue entry type for the register-file write queue.
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/wq_fwd_lookup.sv
// Combinational youngest-match search over the pending queue entries and the
// registered output stage; returns the newest in-flight value for one read port.
module wq_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wq_entry_t         entries_i [DEPTH],
  input  logic [AW-1:0]     head_i,
  input  logic [AW:0]       count_i,
  input  logic              out_valid_i,
  input  logic [REG_AW-1:0] out_rd_i,
  input  logic [DATA_W-1:0] out_data_i,
  input  logic [REG_AW-1:0] rr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (rr_i != ZERO_REG) begin
      // Oldest candidate first so each younger match overrides it.
      if (out_valid_i && (out_rd_i == rr_i)) begin
        hit_o  = 1'b1;
        data_o = out_data_i;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (((AW+1)'(i) < count_i) &&
            (entries_i[head_i + AW'(i)].rd == rr_i)) begin
          hit_o  = 1'b1;
          data_o = entries_i[head_i + AW'(i)].data;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file's single write port,
// with forwarding of pending writes to the two read ports.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  output logic [REG_AW-1:0] wr,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEN,
  input  logic [REG_AW-1:0] rr1,
  input  logic [REG_AW-1:0] rr2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              empty,
  output logic              ovf
);
  wq_entry_t         entries_q [DEPTH];
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d, alu_slot;
  logic [AW:0]       count_q, count_d, free_slots;
  logic              mem_req, alu_req, mem_enq, alu_enq, deq;
  logic              ovf_q, ovf_d, we_q;
  logic [REG_AW-1:0] wr_q;
  logic [DATA_W-1:0] wdata_q;

  assign free_slots = (AW+1)'(DEPTH) - count_q;
  assign mem_req    = mem_valid && (mem_rd != ZERO_REG);
  assign alu_req    = alu_valid && (alu_rd != ZERO_REG);
  // The mem result is the older instruction, so it claims a slot first.
  assign mem_enq    = mem_req && (free_slots != '0);
  assign alu_enq    = alu_req && (free_slots > (AW+1)'(mem_enq));
  assign alu_slot   = tail_q + AW'(mem_enq);
  assign deq        = (count_q != '0);

  always_comb begin
    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(mem_enq) + AW'(alu_enq);
    count_d = count_q + (AW+1)'(mem_enq) + (AW+1)'(alu_enq) - (AW+1)'(deq);
    ovf_d   = ovf_q | (mem_req & ~mem_enq) | (alu_req & ~alu_enq);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      we_q    <= deq;
      if (deq) begin
        wr_q    <= entries_q[head_q].rd;
        wdata_q <= entries_q[head_q].data;
      end
    end
  end

  // Storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge Clk) begin
    if (mem_enq) entries_q[tail_q] <= '{rd: mem_rd, data: mem_data};
    if (alu_enq) entries_q[alu_slot] <= '{rd: alu_rd, data: alu_data};
  end

  assign in_ready  = (free_slots >= (AW+1)'(2));
  assign wr        = wr_q;
  assign writeData = wdata_q;
  assign writeEN   = we_q;
  assign empty     = (count_q == '0) && !we_q;
  assign ovf       = ovf_q;

  wq_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
    .entries_i  (entries_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .out_valid_i(we_q),
    .out_rd_i   (wr_q),
    .out_data_i (wdata_q),
    .rr_i       (rr1),
    .hit_o      (fwd1_hit),
    .data_o     (fwd1_data)
  );

  wq_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
    .entries_i  (entries_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .out_valid_i(we_q),
    .out_rd_i   (wr_q),
    .out_data_i (wdata_q),
    .rr_i       (rr2),
    .hit_o      (fwd2_hit),
    .data_o     (fwd2_data)
  );
endmodule
